// File: rtl/mips_pkg.sv
// mips_pkg: shared load/store type codes, register and data-width constants
package mips_pkg;
    localparam int DATA_W = 32;
    localparam logic [2:0] LS_BYTE  = 3'b000;
    localparam logic [2:0] LS_HALF  = 3'b001;
    localparam logic [2:0] LS_WORD  = 3'b010;
    localparam logic [2:0] LS_WORDU = 3'b011;
    localparam logic [2:0] LS_BYTEU = 3'b100;
    localparam logic [2:0] LS_HALFU = 3'b101;
    localparam logic [4:0] REG_RA   = 5'd31;
endpackage

// File: rtl/data_memory.sv
// data_memory: dual-port sync RAM, port A byte-enable read/write, port B read-only (debug)
//   a_en/a_addr/a_rdata: registered read; a_we/a_wdata: per-byte write at a_addr
//   b_addr/b_rdata: registered read every edge; same-edge writes return old data
module data_memory
    import mips_pkg::*;
#(
    parameter int MEM_DEPTH  = 256,
    parameter int MEM_ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  a_en,
    input  logic [3:0]            a_we,
    input  logic [MEM_ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0]     a_wdata,
    output logic [DATA_W-1:0]     a_rdata,
    input  logic [MEM_ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0]     b_rdata
);
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (a_en) a_rdata <= mem[a_addr];
        b_rdata <= mem[b_addr];
        for (int i = 0; i < 4; i++)
            if (a_we[i]) mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
    end
endmodule

// File: rtl/stage_memory.sv
// stage_memory: EX/MEM register, data memory access and MEM/WB register with forwarding taps
//   i_*/is_*: execution-stage results and control; i_enable advances the pipeline
//   o_EX_MEM_*/o_MEM_WB_*: forwarding and write-back buses; o_halt: sticky stop flag
//   i_dbg_addr/o_dbg_data: debug word read, one-cycle latency, independent of i_enable
module stage_memory
    import mips_pkg::*;
#(
    parameter int MEM_DEPTH  = 256,
    parameter int MEM_ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_enable,
    input  logic [31:0]           i_ALU_res,
    input  logic [31:0]           i_rt_reg,
    input  logic [31:0]           i_pc_to_reg,
    input  logic [4:0]            i_addr_reg_dst,
    input  logic                  is_link,
    input  logic                  is_RegWrite,
    input  logic                  is_MemtoReg,
    input  logic                  is_MemWrite,
    input  logic                  is_MemRead,
    input  logic                  is_stop_pipe,
    input  logic [2:0]            is_load_store_type,
    output logic                  o_EX_MEM_RegWrite,
    output logic [4:0]            o_EX_MEM_Rd,
    output logic [31:0]           o_EX_MEM_reg,
    output logic                  o_MEM_WB_RegWrite,
    output logic [4:0]            o_MEM_WB_Rd,
    output logic [31:0]           o_MEM_WB_reg,
    output logic                  o_halt,
    input  logic [MEM_ADDR_W-1:0] i_dbg_addr,
    output logic [31:0]           o_dbg_data
);
    logic [31:0] ex_alu, ex_rt, ex_pc;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_type;
    logic        ex_link, ex_regwrite, ex_memtoreg, ex_memwrite, ex_memread, ex_stop;
    logic [31:0] wb_val;
    logic [4:0]  wb_rd;
    logic [2:0]  wb_type;
    logic [1:0]  wb_lane;
    logic        wb_regwrite, wb_memtoreg;
    logic        ls_byte, ls_half;
    logic [3:0]  be;
    logic [31:0] wdata, rdata, load_v;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_ff @(posedge clk) begin
        if (rst) begin
            {ex_alu, ex_rt, ex_pc, ex_rd, ex_type} <= '0;
            {ex_link, ex_regwrite, ex_memtoreg, ex_memwrite, ex_memread, ex_stop} <= '0;
        end else if (i_enable) begin
            ex_alu      <= i_ALU_res;
            ex_rt       <= i_rt_reg;
            ex_pc       <= i_pc_to_reg;
            ex_rd       <= i_addr_reg_dst;
            ex_type     <= is_load_store_type;
            ex_link     <= is_link;
            ex_regwrite <= is_RegWrite;
            ex_memtoreg <= is_MemtoReg;
            ex_memwrite <= is_MemWrite;
            ex_memread  <= is_MemRead;
            ex_stop     <= is_stop_pipe;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {wb_val, wb_rd, wb_type, wb_lane, wb_regwrite, wb_memtoreg} <= '0;
        end else if (i_enable) begin
            wb_val      <= o_EX_MEM_reg;
            wb_rd       <= ex_rd;
            wb_type     <= ex_type;
            wb_lane     <= ex_alu[1:0];
            wb_regwrite <= ex_regwrite;
            wb_memtoreg <= ex_memtoreg;
        end
    end

    // Halt latches once stop reaches MEM/WB and ignores i_enable afterwards.
    always_ff @(posedge clk) begin
        if (rst) o_halt <= 1'b0;
        else if (i_enable && ex_stop) o_halt <= 1'b1;
    end

    always_comb begin
        ls_byte = (ex_type == LS_BYTE) || (ex_type == LS_BYTEU);
        ls_half = (ex_type == LS_HALF) || (ex_type == LS_HALFU);
        be      = ls_byte ? 4'b0001 << ex_alu[1:0] : ls_half ? (ex_alu[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata   = ls_byte ? {4{ex_rt[7:0]}} : ls_half ? {2{ex_rt[15:0]}} : ex_rt;
        ld_byte = rdata[{wb_lane, 3'b000} +: 8];
        ld_half = wb_lane[1] ? rdata[31:16] : rdata[15:0];
        load_v  = wb_type == LS_BYTE  ? {{24{ld_byte[7]}}, ld_byte} :
                  wb_type == LS_BYTEU ? {24'b0, ld_byte} :
                  wb_type == LS_HALF  ? {{16{ld_half[15]}}, ld_half} :
                  wb_type == LS_HALFU ? {16'b0, ld_half} : rdata;
    end

    // Reset in the same edge as a pending store must not touch memory.
    data_memory #(.MEM_DEPTH(MEM_DEPTH), .MEM_ADDR_W(MEM_ADDR_W)) u_mem (
        .clk    (clk),
        .a_en   (i_enable && ex_memread && !rst),
        .a_we   (be & {4{i_enable && ex_memwrite && !rst}}),
        .a_addr (ex_alu[MEM_ADDR_W+1:2]),
        .a_wdata(wdata),
        .a_rdata(rdata),
        .b_addr (i_dbg_addr),
        .b_rdata(o_dbg_data)
    );

    assign o_EX_MEM_RegWrite = ex_regwrite;
    assign o_EX_MEM_Rd       = ex_rd;
    assign o_EX_MEM_reg      = ex_link ? ex_pc : ex_alu;
    assign o_MEM_WB_RegWrite = wb_regwrite;
    assign o_MEM_WB_Rd       = wb_rd;
    assign o_MEM_WB_reg      = wb_memtoreg ? load_v : wb_val;
endmodule

// File: tb/tb_stage_memory.sv
// tb_stage_memory: vector table plus scoreboard queues, with hand sequences for hold, reset and halt
module tb_stage_memory;
    logic        clk = 0, rst = 1, i_enable = 0;
    logic [31:0] i_ALU_res = 0, i_rt_reg = 0, i_pc_to_reg = 0;
    logic [4:0]  i_addr_reg_dst = 0;
    logic        is_link = 0, is_RegWrite = 0, is_MemtoReg = 0, is_MemWrite = 0, is_MemRead = 0, is_stop_pipe = 0;
    logic [2:0]  is_load_store_type = 0;
    logic        o_EX_MEM_RegWrite, o_MEM_WB_RegWrite, o_halt;
    logic [4:0]  o_EX_MEM_Rd, o_MEM_WB_Rd;
    logic [31:0] o_EX_MEM_reg, o_MEM_WB_reg, o_dbg_data;
    logic [7:0]  i_dbg_addr = 0;
    int checks = 0, errors = 0;

    stage_memory dut (
        .clk(clk), .rst(rst), .i_enable(i_enable),
        .i_ALU_res(i_ALU_res), .i_rt_reg(i_rt_reg), .i_pc_to_reg(i_pc_to_reg),
        .i_addr_reg_dst(i_addr_reg_dst), .is_link(is_link), .is_RegWrite(is_RegWrite),
        .is_MemtoReg(is_MemtoReg), .is_MemWrite(is_MemWrite), .is_MemRead(is_MemRead),
        .is_stop_pipe(is_stop_pipe), .is_load_store_type(is_load_store_type),
        .o_EX_MEM_RegWrite(o_EX_MEM_RegWrite), .o_EX_MEM_Rd(o_EX_MEM_Rd), .o_EX_MEM_reg(o_EX_MEM_reg),
        .o_MEM_WB_RegWrite(o_MEM_WB_RegWrite), .o_MEM_WB_Rd(o_MEM_WB_Rd), .o_MEM_WB_reg(o_MEM_WB_reg),
        .o_halt(o_halt), .i_dbg_addr(i_dbg_addr), .o_dbg_data(o_dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu, rt, pc, exp;
        logic [4:0]  rd;
        logic [2:0]  ty;
        logic        link, rw, m2r, mw, mr;
    } vec_t;

    typedef struct {
        logic [31:0] v;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;

    exp_t wbq[$], exq[$];
    vec_t v[27];

    function automatic vec_t ld(input logic [2:0] ty, input logic [31:0] a, input logic [31:0] e);
        vec_t x = '{alu: a, rt: 0, pc: 0, exp: e, rd: 5'd2, ty: ty, link: 0, rw: 1, m2r: 1, mw: 0, mr: 1};
        return x;
    endfunction

    function automatic vec_t st(input logic [2:0] ty, input logic [31:0] a, input logic [31:0] d);
        vec_t x = '{alu: a, rt: d, pc: 0, exp: a, rd: 5'd0, ty: ty, link: 0, rw: 0, m2r: 0, mw: 1, mr: 0};
        return x;
    endfunction

    function automatic vec_t nop();
        vec_t x = '{alu: 0, rt: 0, pc: 0, exp: 0, rd: 0, ty: 0, link: 0, rw: 0, m2r: 0, mw: 0, mr: 0};
        return x;
    endfunction

    task automatic drive(input vec_t x);
        i_ALU_res = x.alu; i_rt_reg = x.rt; i_pc_to_reg = x.pc; i_addr_reg_dst = x.rd;
        is_load_store_type = x.ty; is_link = x.link; is_RegWrite = x.rw;
        is_MemtoReg = x.m2r; is_MemWrite = x.mw; is_MemRead = x.mr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ex_rw"}, {31'b0, o_EX_MEM_RegWrite}, 0);
        chk({tag, "_ex_rd"}, {27'b0, o_EX_MEM_Rd}, 0);
        chk({tag, "_ex_reg"}, o_EX_MEM_reg, 0);
        chk({tag, "_wb_rw"}, {31'b0, o_MEM_WB_RegWrite}, 0);
        chk({tag, "_wb_rd"}, {27'b0, o_MEM_WB_Rd}, 0);
        chk({tag, "_wb_reg"}, o_MEM_WB_reg, 0);
        chk({tag, "_halt"}, {31'b0, o_halt}, 0);
    endtask

    task automatic issue(input vec_t x, input int i);
        exp_t e;
        drive(x);
        wbq.push_back('{v: x.exp, rd: x.rd, rw: x.rw});
        exq.push_back('{v: x.link ? x.pc : x.alu, rd: x.rd, rw: x.rw});
        step();
        e = exq.pop_front();
        chk($sformatf("ex_reg[%0d]", i), o_EX_MEM_reg, e.v);
        chk($sformatf("ex_rd[%0d]", i), {27'b0, o_EX_MEM_Rd}, {27'b0, e.rd});
        chk($sformatf("ex_rw[%0d]", i), {31'b0, o_EX_MEM_RegWrite}, {31'b0, e.rw});
        if (wbq.size() >= 2) begin
            e = wbq.pop_front();
            chk($sformatf("wb_reg[%0d]", i), o_MEM_WB_reg, e.v);
            chk($sformatf("wb_rd[%0d]", i), {27'b0, o_MEM_WB_Rd}, {27'b0, e.rd});
            chk($sformatf("wb_rw[%0d]", i), {31'b0, o_MEM_WB_RegWrite}, {31'b0, e.rw});
        end
    endtask

    initial begin
        v[0]  = st(3'b010, 32'h10, 32'hDEADBEEF);
        v[1]  = ld(3'b010, 32'h10, 32'hDEADBEEF);
        v[2]  = st(3'b010, 32'h20, 32'h0);
        v[3]  = st(3'b000, 32'h21, 32'h000000F0);
        v[4]  = ld(3'b010, 32'h20, 32'h0000F000);
        v[5]  = ld(3'b000, 32'h21, 32'hFFFFFFF0);
        v[6]  = ld(3'b100, 32'h21, 32'h000000F0);
        v[7]  = st(3'b001, 32'h22, 32'h00008001);
        v[8]  = ld(3'b001, 32'h22, 32'hFFFF8001);
        v[9]  = ld(3'b101, 32'h22, 32'h00008001);
        v[10] = ld(3'b010, 32'h20, 32'h8001F000);
        v[11] = '{alu: 32'h1234, rt: 0, pc: 0, exp: 32'h1234, rd: 5'd5, ty: 3'b010, link: 0, rw: 1, m2r: 0, mw: 0, mr: 0};
        v[12] = '{alu: 32'h999, rt: 0, pc: 32'h40, exp: 32'h40, rd: 5'd31, ty: 3'b010, link: 1, rw: 1, m2r: 0, mw: 0, mr: 0};
        v[13] = ld(3'b010, 32'h13, 32'hDEADBEEF);
        v[14] = ld(3'b010, 32'h410, 32'hDEADBEEF);
        v[15] = ld(3'b000, 32'h13, 32'hFFFFFFDE);
        v[16] = ld(3'b101, 32'h12, 32'h0000DEAD);
        v[17] = ld(3'b110, 32'h10, 32'hDEADBEEF);
        v[18] = ld(3'b011, 32'h10, 32'hDEADBEEF);
        v[19] = ld(3'b010, 32'h10, 32'hDEADBEEF);
        v[19].link = 1; v[19].pc = 32'h44;
        v[20] = st(3'b010, 32'h30, 32'h11111111);
        v[21] = st(3'b001, 32'h23, 32'h12347777);
        v[22] = ld(3'b010, 32'h20, 32'h7777F000);
        v[23] = ld(3'b001, 32'h21, 32'hFFFFF000);
        v[24] = st(3'b000, 32'h20, 32'h000000AB);
        v[25] = ld(3'b100, 32'h20, 32'h000000AB);
        v[26] = ld(3'b000, 32'h20, 32'hFFFFFFAB);

        drive(nop());
        repeat (3) step();
        rst = 0;
        chk_idle("reset");
        i_enable = 1;

        foreach (v[i]) issue(v[i], i);
        issue(nop(), 100);
        issue(nop(), 101);

        // Hold with a store pending in EX/MEM
        i_dbg_addr = 8'd12;
        drive(st(3'b010, 32'h30, 32'hAAAA5555));
        step();
        chk("hold_ex_reg_pre", o_EX_MEM_reg, 32'h30);
        i_enable = 0;
        drive('{alu: 32'h777, rt: 0, pc: 0, exp: 0, rd: 5'd7, ty: 3'b010, link: 0, rw: 1, m2r: 0, mw: 0, mr: 0});
        repeat (3) step();
        chk("hold_ex_reg", o_EX_MEM_reg, 32'h30);
        chk("hold_ex_rd", {27'b0, o_EX_MEM_Rd}, 0);
        chk("hold_wb_reg", o_MEM_WB_reg, 0);
        chk("hold_wb_rw", {31'b0, o_MEM_WB_RegWrite}, 0);
        chk("hold_mem", o_dbg_data, 32'h11111111);
        i_dbg_addr = 8'd4;
        step();
        chk("hold_dbg_tracks", o_dbg_data, 32'hDEADBEEF);
        i_dbg_addr = 8'd12;
        i_enable = 1;
        drive(nop());
        step();
        chk("dbg_rdw_old", o_dbg_data, 32'h11111111);
        chk("hold_release_wb", o_MEM_WB_reg, 32'h30);
        step();
        chk("hold_store_done", o_dbg_data, 32'hAAAA5555);

        // Reset drops the store sitting in EX/MEM
        drive(st(3'b010, 32'h30, 32'h55555555));
        step();
        rst = 1;
        drive(nop());
        step();
        rst = 0;
        chk_idle("rst_mid");
        step();
        chk("rst_no_write", o_dbg_data, 32'hAAAA5555);

        // Halt is sticky through a hold
        drive(nop());
        is_stop_pipe = 1;
        step();
        is_stop_pipe = 0;
        chk("halt_1edge", {31'b0, o_halt}, 0);
        step();
        chk("halt_2edge", {31'b0, o_halt}, 1);
        i_enable = 0;
        repeat (3) step();
        chk("halt_sticky", {31'b0, o_halt}, 1);
        rst = 1;
        step();
        rst = 0;
        chk("halt_cleared", {31'b0, o_halt}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/stage_memory.md
Name: stage_memory

Overview:
- Consumer end of the execution-stage output bus: owns the EX/MEM pipeline register, the data memory and the MEM/WB pipeline register.
- Performs byte/half/word loads and stores with sign/zero extension and selects write-back data.
- Sources the EX_MEM and MEM_WB forwarding buses back to the execution stage's forward unit.
- Offers a debug read port into data memory for the debug unit.

Parameters:
- MEM_DEPTH, 256, number of 32-bit words in data memory.
- MEM_ADDR_W, 8, word-address width; must equal log2(MEM_DEPTH).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- i_enable  in  1  global pipeline advance (debug step); 0 = hold all state, no memory write
- i_ALU_res  in  32  byte address for loads/stores, or ALU result
- i_rt_reg  in  32  store data (already forwarded)
- i_pc_to_reg  in  32  link value for jal/jalr
- i_addr_reg_dst  in  5  destination register
- is_link  in  1  write-back selects i_pc_to_reg
- is_RegWrite, is_MemtoReg, is_MemWrite, is_MemRead, is_stop_pipe  in  1 each  control from EX
- is_load_store_type  in  3  access type, encoding below
- o_EX_MEM_RegWrite  out  1  forwarding: EX/MEM RegWrite
- o_EX_MEM_Rd  out  5  forwarding: EX/MEM destination
- o_EX_MEM_reg  out  32  forwarding: EX/MEM value (pc_to_reg if link, else ALU_res)
- o_MEM_WB_RegWrite  out  1  write-back enable
- o_MEM_WB_Rd  out  5  write-back destination
- o_MEM_WB_reg  out  32  write-back data
- o_halt  out  1  stop_pipe reached MEM/WB
- i_dbg_addr  in  MEM_ADDR_W  debug word address
- o_dbg_data  out  32  debug read data, 1-cycle latency

Behaviour:
- Reset: synchronous, active-high. On rst=1 at a rising edge:
  - All EX/MEM and MEM/WB fields clear to 0, so every o_* output reads 0 and o_halt=0.
  - Memory contents are not cleared.
  - Reset mid-operation drops any in-flight store; no memory write occurs in the reset cycle.
- Pipeline timing: EX/MEM captures inputs on the edge with i_enable=1. MEM/WB captures from EX/MEM on the same edge.
- Latency: input to o_MEM_WB_* is 2 edges; input to o_EX_MEM_* is 1 edge.
- Hold: i_enable=0 freezes both registers and suppresses memory writes. o_dbg_data still updates.
- Access type encoding (is_load_store_type):
  - 000 byte signed (LB/SB)
  - 001 half signed (LH/SH)
  - 010 word (LW/SW)
  - 011 word unsigned (LWU)
  - 100 byte unsigned (LBU)
  - 101 half unsigned (LHU)
  - 110, 111 treated as word
- Address decode:
  - Word index = ALU_res[MEM_ADDR_W+1:2]; upper bits ignored, so addresses wrap modulo MEM_DEPTH*4.
  - Little-endian lanes: byte lane = ALU_res[1:0]; half lane = ALU_res[1].
  - Misaligned half/word accesses force alignment by ignoring the low bits.
- Store:
  - Write occurs at the edge when EX/MEM MemWrite=1 and i_enable=1.
  - Byte-enable mask per type/lane; data replicated into the lane. SB writes rt[7:0], SH writes rt[15:0], SW writes all 32 bits.
- Load:
  - Synchronous read, addressed from EX/MEM at the edge that loads MEM/WB.
  - Lane extraction plus sign/zero extension is applied combinationally from registered type and lane bits held in MEM/WB.
- Write-back select, priority order: MemtoReg then load data; else link then pc_to_reg; else ALU_res.
- Read-during-write, same word on the same edge: the load returns old data. This cannot occur within one instruction. Bench checks back-to-back SW then LW to the same address returns the new data.
- Halt:
  - o_halt rises when a stop_pipe instruction reaches MEM/WB.
  - It is sticky until rst and does not depend on i_enable after it is set.
  - Stores already in EX/MEM still complete.
- Debug read: o_dbg_data = mem[i_dbg_addr] registered every edge, independent of i_enable. A debug read of a word being written on the same edge returns old data.

Decomposition:
- Shared package `mips_pkg`:
  - Load/store type constants (LS_BYTE, LS_HALF, LS_WORD, LS_WORDU, LS_BYTEU, LS_HALFU).
  - Register 31 constant.
  - Data width 32.
- Sub-module data_memory: dual-port synchronous RAM with a 4-bit byte-enable write port (port A read/write) and a read-only port B for debug; MEM_DEPTH parameter passed through.
- Lane selection and extension stay in stage_memory.

Test Plan:
- Reset then idle -> all o_* = 0, o_halt = 0; assert rst with a store in EX/MEM -> memory word unchanged.
- SW rt=0xDEADBEEF addr 0x10, then LW addr 0x10 -> o_MEM_WB_reg = 0xDEADBEEF two edges after the LW input.
- Store bytes at 0x20:
  - SB rt=0x000000F0 at 0x21 -> word = 0x0000F000.
  - LB 0x21 -> 0xFFFFFFF0; LBU 0x21 -> 0x000000F0.
  - SH 0x8001 at 0x22, LH 0x22 -> 0xFFFF8001; LHU -> 0x00008001.
- Forwarding: ALU op Rd=5 res=0x1234 RegWrite=1 -> next cycle o_EX_MEM_Rd=5, o_EX_MEM_reg=0x1234, o_EX_MEM_RegWrite=1; following cycle same on MEM_WB.
- jal (is_link=1, Rd=31, pc_to_reg=0x40) -> o_MEM_WB_reg = 0x40, o_MEM_WB_Rd = 31.
- Hold and halt:
  - i_enable=0 with SW pending -> memory and outputs unchanged, o_dbg_data still tracks i_dbg_addr.
  - stop_pipe input -> o_halt=1 after 2 edges and stays 1 with i_enable=0.
